// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command sequencer.
package spi_cmd_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;
   localparam int BYTE_W = 8;
   localparam int CMD_RW_BIT = 7;
   localparam int DEF_TIMEOUT_CYCLES = 16000;
   // Command bits between the R/W flag and the address field must be zero.
   function automatic logic [7:0] resv_mask(input int aw);
      resv_mask = 8'h7F & ~8'((1 << aw) - 1);
   endfunction
endpackage

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: byte register bank with one synchronous write port and one combinational read port.
module spi_reg_bank import spi_cmd_pkg::*; #(
   parameter int ADDR_W = 3
)(
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              we,
   input  logic [ADDR_W-1:0]                 waddr,
   input  logic [BYTE_W-1:0]                 wdata,
   input  logic [ADDR_W-1:0]                 raddr,
   output logic [BYTE_W-1:0]                 rdata,
   output logic [BYTE_W*(2**ADDR_W)-1:0]     reg_out
);
   logic [BYTE_W-1:0] regs [2**ADDR_W];
   always_ff @(posedge CLK)
      if (RST) for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      else if (we) regs[waddr] <= wdata;
   for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_out
      assign reg_out[BYTE_W*k +: BYTE_W] = regs[k];
   end
   assign rdata = regs[raddr];
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: parses per-frame SPI bytes into burst register writes/reads,
// supplies the next byte to shift out, and flags malformed or stalled frames.
module spi_cmd_ctrl import spi_cmd_pkg::*; #(
   parameter int ADDR_W         = 3,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int TIMEOUT_W      = 14
)(
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [7:0]                    rx_byte,
   input  logic                          rx_valid,
   input  logic                          cs_n,
   input  logic                          err_clr,
   output logic [8*(2**ADDR_W)-1:0]      reg_out,
   output logic                          wr_strobe,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [7:0]                    wr_data,
   output logic [7:0]                    tx_byte,
   output logic                          frame_err,
   output logic                          timeout_err
);
   state_t state, state_nxt;
   logic [ADDR_W-1:0] addr, raddr;
   logic [TIMEOUT_W-1:0] to_cnt;
   logic [7:0] rdata;
   logic fire, active, to_hit, cmd_bad, we, tx_load;

   assign fire    = rx_valid && !cs_n;
   assign active  = (state == WRITE || state == READ) && !cs_n;
   assign cmd_bad = |(rx_byte & resv_mask(ADDR_W));
   assign to_hit  = active && !rx_valid && to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   // A reset released mid-frame must not treat the next byte as a command.
   always_ff @(posedge CLK)
      if (RST) state <= cs_n ? IDLE : DISCARD;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (cs_n) state_nxt = IDLE;
      else if (state == IDLE && rx_valid)
         state_nxt = cmd_bad ? DISCARD : rx_byte[CMD_RW_BIT] ? WRITE : READ;
      else if (to_hit) state_nxt = DISCARD;
   end

   always_comb begin
      we      = state == WRITE && fire;
      raddr   = state == IDLE ? rx_byte[ADDR_W-1:0] : addr + 1'b1;
      tx_load = fire && (state == READ || (state == IDLE && !cmd_bad && !rx_byte[CMD_RW_BIT]));
   end

   always_ff @(posedge CLK)
      if (RST) begin
         addr        <= '0;
         to_cnt      <= '0;
         tx_byte     <= '0;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         addr        <= (fire && state == IDLE) ? rx_byte[ADDR_W-1:0] :
                        (fire && (state == WRITE || state == READ)) ? addr + 1'b1 : addr;
         to_cnt      <= (active && !rx_valid && !to_hit) ? to_cnt + 1'b1 : '0;
         tx_byte     <= tx_load ? rdata : tx_byte;
         wr_strobe   <= we;
         wr_addr     <= we ? addr : wr_addr;
         wr_data     <= we ? rx_byte : wr_data;
         frame_err   <= (fire && state == IDLE && cmd_bad) || (frame_err && !err_clr);
         timeout_err <= to_hit || (timeout_err && !err_clr);
      end

   spi_reg_bank #(.ADDR_W(ADDR_W)) u_bank (
      .CLK    (CLK),
      .RST    (RST),
      .we     (we),
      .waddr  (addr),
      .wdata  (rx_byte),
      .raddr  (raddr),
      .rdata  (rdata),
      .reg_out(reg_out)
   );
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed self-checking bench for spi_cmd_ctrl.
module tb_spi_cmd_ctrl;
   logic CLK = 1'b0, RST = 1'b1;
   logic [7:0] rx_byte = '0;
   logic rx_valid = 1'b0, cs_n = 1'b1, err_clr = 1'b0;
   logic [63:0] reg_out;
   logic wr_strobe, frame_err, timeout_err;
   logic [2:0] wr_addr;
   logic [7:0] wr_data, tx_byte;
   int n_cmp = 0, n_err = 0, n_wr = 0, w0;

   spi_cmd_ctrl dut (
      .CLK(CLK), .RST(RST), .rx_byte(rx_byte), .rx_valid(rx_valid), .cs_n(cs_n),
      .err_clr(err_clr), .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
      .wr_data(wr_data), .tx_byte(tx_byte), .frame_err(frame_err), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;
   always @(negedge CLK) if (wr_strobe) n_wr++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rg(input int k);
      return 64'(reg_out[8*k +: 8]);
   endfunction

   task automatic send(input logic [7:0] b);
      @(posedge CLK); #1 rx_byte = b; rx_valid = 1'b1;
      @(posedge CLK); #1 rx_valid = 1'b0;
   endtask

   task automatic start_frame;
      @(posedge CLK); #1 cs_n = 1'b0;
   endtask

   task automatic end_frame;
      @(posedge CLK); #1 cs_n = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic pulse_clr;
      @(posedge CLK); #1 err_clr = 1'b1;
      @(posedge CLK); #1 err_clr = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      chk("rst_reg_out", reg_out, 64'h0);
      chk("rst_tx_byte", 64'(tx_byte), 64'h0);
      chk("rst_wr_strobe", 64'(wr_strobe), 64'h0);
      chk("rst_frame_err", 64'(frame_err), 64'h0);
      chk("rst_timeout_err", 64'(timeout_err), 64'h0);

      // burst write 6,7,0
      start_frame;
      send(8'h86);
      chk("wr_cmd_no_strobe", 64'(n_wr), 64'd0);
      send(8'hAA);
      chk("wr6_strobe", 64'(wr_strobe), 64'h1);
      chk("wr6_addr", 64'(wr_addr), 64'd6);
      chk("wr6_data", 64'(wr_data), 64'hAA);
      chk("wr6_reg", rg(6), 64'hAA);
      @(posedge CLK); #1;
      chk("wr_strobe_one_cycle", 64'(wr_strobe), 64'h0);
      send(8'hBB);
      chk("wr7_addr", 64'(wr_addr), 64'd7);
      chk("wr7_reg", rg(7), 64'hBB);
      send(8'hCC);
      chk("wr0_addr", 64'(wr_addr), 64'd0);
      chk("wr0_reg", rg(0), 64'hCC);
      end_frame;
      chk("wr_count", 64'(n_wr), 64'd3);
      chk("wr_bank", reg_out, 64'hBBAA_0000_0000_00CC);

      // burst read 7,0,1
      w0 = n_wr;
      start_frame;
      send(8'h07);
      chk("rd_tx_cmd", 64'(tx_byte), 64'hBB);
      send(8'h5A);
      chk("rd_tx_d1", 64'(tx_byte), 64'hCC);
      repeat (3) @(posedge CLK);
      #1 chk("rd_tx_stable", 64'(tx_byte), 64'hCC);
      send(8'hA5);
      chk("rd_tx_d2", 64'(tx_byte), 64'h00);
      end_frame;
      chk("rd_no_write", 64'(n_wr), 64'(w0));
      chk("rd_tx_hold", 64'(tx_byte), 64'h00);

      // malformed command
      start_frame;
      send(8'hC1);
      send(8'h55);
      chk("bad_frame_err", 64'(frame_err), 64'h1);
      chk("bad_reg1", rg(1), 64'h0);
      chk("bad_no_write", 64'(n_wr), 64'(w0));
      end_frame;
      pulse_clr;
      chk("clr_frame_err", 64'(frame_err), 64'h0);
      start_frame;
      send(8'h81);
      send(8'h55);
      end_frame;
      chk("good_reg1", rg(1), 64'h55);

      // timeout
      start_frame;
      send(8'h82);
      repeat (15999) @(posedge CLK);
      #1 chk("to_not_yet", 64'(timeout_err), 64'h0);
      @(posedge CLK); #1;
      chk("to_set", 64'(timeout_err), 64'h1);
      w0 = n_wr;
      send(8'h11);
      chk("to_reg2", rg(2), 64'h0);
      chk("to_no_write", 64'(n_wr), 64'(w0));
      end_frame;
      start_frame;
      send(8'h82);
      send(8'h11);
      end_frame;
      chk("to_resync_reg2", rg(2), 64'h11);
      chk("to_sticky", 64'(timeout_err), 64'h1);
      pulse_clr;
      chk("clr_timeout_err", 64'(timeout_err), 64'h0);

      // command only, then rx_valid coinciding with cs_n rising
      w0 = n_wr;
      start_frame;
      send(8'h83);
      @(posedge CLK); #1 cs_n = 1'b1; rx_byte = 8'h99; rx_valid = 1'b1;
      @(posedge CLK); #1 rx_valid = 1'b0;
      @(posedge CLK); #1;
      chk("csn_reg3", rg(3), 64'h0);
      chk("csn_no_write", 64'(n_wr), 64'(w0));

      // reset mid-frame
      start_frame;
      send(8'h85);
      send(8'h77);
      chk("mid_reg5", rg(5), 64'h77);
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      chk("mid_rst_bank", reg_out, 64'h0);
      w0 = n_wr;
      send(8'h66);
      send(8'h44);
      chk("mid_ignored_bank", reg_out, 64'h0);
      chk("mid_ignored_wr", 64'(n_wr), 64'(w0));
      end_frame;
      start_frame;
      send(8'h85);
      send(8'h12);
      end_frame;
      chk("post_rst_reg5", rg(5), 64'h12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer sitting between the Spi slave receiver and the design's control outputs (LEDs, pins, display parameters). Parses the received byte stream per frame (cs_n low) into write/read transactions on a small register bank, with burst auto-increment. Provides the next byte to shift back to the master, and sticky error flags for malformed or stalled frames.

Parameters:
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (8 by default)
TIMEOUT_CYCLES, 16000, idle cycles inside a frame before abort (1 ms at 16 MHz)
TIMEOUT_W, 14, counter width; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock, 16 MHz
RST  in  1  synchronous, active-high reset
rx_byte  in  8  last byte received by Spi, valid when rx_valid=1
rx_valid  in  1  one-cycle pulse per received byte
cs_n  in  1  slave select, active low, already synchronised to CLK upstream
err_clr  in  1  one-cycle pulse; clears frame_err and timeout_err
reg_out  out  8*NUM_REGS  register bank contents, reg k at [8k+7:8k]
wr_strobe  out  1  one-cycle pulse per completed register write
wr_addr  out  ADDR_W  address of the current/last write
wr_data  out  8  data of the current/last write
tx_byte  out  8  byte Spi shifts out on the next transfer
frame_err  out  1  sticky: malformed command byte seen
timeout_err  out  1  sticky: in-frame timeout occurred

Behaviour:
- Reset: state IDLE, all registers 0, reg_out/wr_*/tx_byte 0, wr_strobe 0, both error flags 0, timeout counter 0.
- Command byte (first rx_valid of a frame): bit7 = 1 write / 0 read; bits[6:ADDR_W] reserved, must be 0; bits[ADDR_W-1:0] = start address.
- States: IDLE, WRITE, READ, DISCARD.
- IDLE: cs_n high -> stay. rx_valid with cs_n low -> latch address, then:
  - reserved bits nonzero -> DISCARD, frame_err<=1;
  - bit7 = 1 -> WRITE;
  - bit7 = 0 -> READ, tx_byte<=reg[addr] on the same edge.
- WRITE: each rx_valid -> reg[addr]<=rx_byte, wr_strobe=1, wr_addr=addr, wr_data=rx_byte, all registered on the edge after the rx_valid cycle (reg_out updated one cycle after rx_valid); then addr<=addr+1 mod NUM_REGS (7 wraps to 0).
- READ: each rx_valid (dummy byte, content ignored) -> addr<=addr+1 mod NUM_REGS; tx_byte<=reg[addr+1]. tx_byte stays stable between rx_valid pulses.
- DISCARD: ignore all bytes until cs_n high.
- cs_n high in any state -> IDLE on the next edge. A rx_valid coinciding with cs_n high is dropped (no write, no address change). tx_byte holds its value.
- Timeout: in WRITE/READ, counter increments each cycle without rx_valid and clears on rx_valid. Reaching TIMEOUT_CYCLES -> timeout_err<=1, state DISCARD (frame resync requires cs_n high). Counter is 0 in IDLE/DISCARD.
- err_clr clears both flags. If a set condition occurs in the same cycle, the set wins.
- RST mid-frame: immediate return to reset values, including register contents. The following bytes are ignored until cs_n goes high and a new frame starts. This uses the DISCARD state when cs_n is low at reset release.
- wr_strobe never asserts outside WRITE. At most one write per rx_valid.

Decomposition:
- Package spi_cmd_pkg:
  - state enum (IDLE, WRITE, READ, DISCARD);
  - CMD_RW_BIT = 7;
  - reserved-bit mask function of ADDR_W;
  - default TIMEOUT_CYCLES.
- One sub-module spi_reg_bank: NUM_REGS x 8 registers, with a synchronous write port (we, waddr, wdata), a combinational read port (raddr -> rdata), a flat reg_out bus, and synchronous reset to 0.
- FSM, address counter and timeout counter stay in spi_cmd_ctrl.

Test Plan:
- Reset sequence:
  - Stimulus: RST held 2 cycles.
  - Required response: reg_out=0, tx_byte=0, wr_strobe=0, frame_err=0, timeout_err=0.
- Burst write with wrap:
  - Stimulus: frame 0x86,0xAA,0xBB,0xCC.
  - Required response: reg6=0xAA, reg7=0xBB, reg0=0xCC. Three wr_strobe pulses with wr_addr 6,7,0, each one cycle after its rx_valid.
- Burst read:
  - Stimulus: after the write test, frame 0x07 then two dummy bytes.
  - Required response: tx_byte=0xBB after the command byte, 0xCC after the first dummy, then reg1=0x00. No wr_strobe.
- Malformed command:
  - Stimulus: frame 0xC1,0x55.
  - Required response: frame_err=1, reg1 unchanged, no wr_strobe.
  - Follow-up: err_clr -> frame_err=0; the next frame 0x81,0x55 writes reg1=0x55.
- Timeout:
  - Stimulus: 0x82, then cs_n held low with no bytes for 16000 cycles, then 0x11.
  - Required response: timeout_err=1, reg2 not written. After cs_n high and frame 0x82,0x11 -> reg2=0x11.
- cs_n edge cases:
  - rx_valid in the same cycle cs_n rises -> byte dropped.
  - cs_n high after the command 0x83 only -> IDLE, no writes.
  - RST pulsed mid-write frame with cs_n low -> registers 0, remaining bytes ignored until cs_n high.
